wb_arbiter: RTL

Writeback arbiter feeding the single write port of the 32×XLEN general-purpose register file. It merges results from the single-cycle ALU pipe and from the long-latency LSU/MDU return path, buffering the latter in a small in-order queue. It drives the register file's `reg_wen`/`reg_wnum`/`rwdata` from registered outputs and exports a pending-write mask and an ALU stall request to issue logic.

---
 rtl/rv_pkg.sv | 15 +
 rtl/wb_fifo.sv | 86 ++++++++
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the writeback path.
//   XLEN     - general-purpose register width
//   REG_W    - register index width (32 architectural registers)
//   wb_req_t - one pending register-file write {rd, data}
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small in-order queue of wb_req_t entries for long-latency results.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the queue)
//   push, din - enqueue din at the tail (caller never pushes when full)
//   pop       - dequeue the head (caller never pops when empty)
//   head      - current head entry (combinational read of the storage)
//   count     - occupancy, 0..DEPTH
//   full      - count == DEPTH
//   empty     - count == 0
//   valid     - per-slot occupancy bits
//   rd_flat   - rd of every slot, slot i at [i*REG_W +: REG_W]; qualify with valid
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                din,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       valid,
  output logic [DEPTH*REG_W-1:0] rd_flat
);

  wb_req_t          mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;

  // Storage has no reset: occupancy is tracked by valid_reg/count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign valid_next[gi] = (valid_reg[gi] && !(pop && rd_ptr_reg == PW'(gi)))
                            || (push && wr_ptr_reg == PW'(gi));
      assign rd_flat[gi*REG_W +: REG_W] = mem[gi].rd;
    end
  endgenerate

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      valid_reg <= valid_next;
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign valid = valid_reg;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the single register-file write port.
// Merges the single-cycle ALU pipe with the long-latency LSU/MDU return path,
// which is buffered in an in-order queue when it loses the write slot.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     - ALU result (never refused)
//   lsu_valid/lsu_rd/lsu_data     - long-latency result offer
//   lsu_ready                     - long-latency result accepted (occupancy only)
//   reg_wen/reg_wnum/rwdata       - registered register-file write port
//   pend_mask                     - one bit per register targeted by a queued entry
//   alu_stall                     - registered request to hold off alu_valid
module wb_arbiter
  import rv_pkg::wb_req_t;
  import rv_pkg::REG_W;
#(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  output logic             reg_wen,
  output logic [4:0]       reg_wnum,
  output logic [XLEN-1:0]  rwdata,
  output logic [31:0]      pend_mask,
  output logic             alu_stall
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t                  lq_head;
  wb_req_t                  enq_req;
  logic [CW-1:0]            lq_count;
  logic                     lq_full;
  logic                     lq_empty;
  logic [LQ_DEPTH-1:0]      lq_valid;
  logic [LQ_DEPTH*REG_W-1:0] lq_rd_flat;

  logic alu_w;
  logic lsu_xfer;
  logic lsu_w;
  logic sel_alu;
  logic deq;
  logic byp;
  logic enq;

  logic            wen_reg;
  logic            wen_next;
  logic [4:0]      wnum_reg;
  logic [4:0]      wnum_next;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] wdata_next;
  logic [SW-1:0]   starve_reg;
  logic [SW-1:0]   starve_next;
  logic            stall_reg;

  assign lsu_ready = !rst && (lq_count < CW'(LQ_DEPTH));
  assign lsu_xfer  = lsu_valid && lsu_ready;
  // rd=0 results are accepted but dropped: they never take a slot or queue entry.
  assign lsu_w     = lsu_xfer && (lsu_rd != '0);
  assign alu_w     = alu_valid && (alu_rd != '0);

  // Priority: unstalled ALU, then queue head, then empty-queue bypass.
  always_comb begin
    sel_alu    = alu_w && !stall_reg;
    deq        = !sel_alu && !lq_empty;
    byp        = !sel_alu && lq_empty && lsu_w;
    enq        = lsu_w && !byp;
    wen_next   = 1'b0;
    wnum_next  = wnum_reg;
    wdata_next = wdata_reg;
    if (sel_alu) begin
      wen_next   = 1'b1;
      wnum_next  = alu_rd;
      wdata_next = alu_data;
    end else if (deq) begin
      wen_next   = 1'b1;
      wnum_next  = lq_head.rd;
      wdata_next = lq_head.data;
    end else if (byp) begin
      wen_next   = 1'b1;
      wnum_next  = lsu_rd;
      wdata_next = lsu_data;
    end
  end

  // Counts cycles a waiting head loses to the ALU; any dequeue or an empty
  // queue restarts the count.
  always_comb begin
    starve_next = starve_reg;
    if (lq_empty || deq) begin
      starve_next = '0;
    end else if (starve_reg != SW'(STARVE_LIMIT)) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  assign enq_req = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .rst     (rst),
    .push    (enq),
    .din     (enq_req),
    .pop     (deq),
    .head    (lq_head),
    .count   (lq_count),
    .full    (lq_full),
    .empty   (lq_empty),
    .valid   (lq_valid),
    .rd_flat (lq_rd_flat)
  );

  logic [31:0] entry_mask [LQ_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < LQ_DEPTH; gi++) begin : g_pend
      assign entry_mask[gi] = lq_valid[gi] ? (32'h1 << lq_rd_flat[gi*REG_W +: REG_W]) : 32'h0;
    end
  endgenerate

  always_comb begin
    pend_mask = 32'h0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      pend_mask = pend_mask | entry_mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_reg    <= 1'b0;
      wnum_reg   <= '0;
      wdata_reg  <= '0;
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      wen_reg    <= wen_next;
      wnum_reg   <= wnum_next;
      wdata_reg  <= wdata_next;
      starve_reg <= starve_next;
      stall_reg  <= (starve_next == SW'(STARVE_LIMIT));
    end
  end

  assign reg_wen   = wen_reg;
  assign reg_wnum  = wnum_reg;
  assign rwdata    = wdata_reg;
  assign alu_stall = stall_reg;

  // Issue logic must not present an ALU result while the stall is up.
  a_no_alu_in_stall: assert property (@(posedge clk) disable iff (rst) !(alu_valid && stall_reg));
  // Ready is derived from occupancy, so a full queue is never pushed.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(enq && lq_full));

endmodule
